// File: rtl/alu_pkg.sv
// Shared opcode encoding, multiplier FSM states and opcode legality check
// for the pipelined Beta ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'b00000,
    OP_SUB   = 5'b00001,
    OP_MUL   = 5'b00010,
    OP_CMPEQ = 5'b00101,
    OP_CMPLT = 5'b00111,
    OP_CMPLE = 5'b01111,
    OP_SHL   = 5'b01000,
    OP_SHR   = 5'b01001,
    OP_SRA   = 5'b01011,
    OP_AND   = 5'b11000,
    OP_OR    = 5'b11110,
    OP_XOR   = 5'b10110
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Any opcode with this MSB is a BOOL op; the low four bits are its truth table.
  localparam logic BOOL_PREFIX = 1'b1;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_CMPEQ, OP_CMPLT, OP_CMPLE,
      OP_SHL, OP_SHR, OP_SRA: return 1'b1;
      default:                return op[4] == BOOL_PREFIX;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-and-add multiplier retiring MUL_STEP bits of b per cycle.
// last is high during the final accumulation cycle; product is valid after it.
module alu_mul_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] product
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CW    = $clog2(STEPS) + 1;

  logic [WIDTH-1:0] a_sh, b_sh, acc, pp;
  logic [CW-1:0]    cnt;
  logic             busy;

  // Only the low WIDTH bits of each partial product can reach the result.
  assign pp      = a_sh * {{(WIDTH-MUL_STEP){1'b0}}, b_sh[MUL_STEP-1:0]};
  assign last    = busy & (cnt == '0);
  assign product = acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (start) begin
      a_sh <= a;
      b_sh <= b;
      acc  <= '0;
      cnt  <= CW'(STEPS - 1);
      busy <= 1'b1;
    end else if (busy) begin
      acc  <= acc + pp;
      a_sh <= a_sh << MUL_STEP;
      b_sh <= b_sh >> MUL_STEP;
      cnt  <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered, valid/ready Beta ALU with an iterative multiplier.
//   state | meaning
//   IDLE  | accepting ops; single-cycle results go straight to the output register
//   BUSY  | multiplier accumulating, input stalled
//   DONE  | product ready, waiting for the output register to free up
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;

  mul_state_e       state, state_nx;
  logic             out_free, accept, mul_start, mul_last, load_alu, load_mul;
  logic [WIDTH-1:0] product, sum, diff, bool_y, r_y;
  logic             r_z, r_v, r_n, r_ill, v_add, v_sub, lt;
  logic [SHW-1:0]   shamt;

  assign out_free  = !out_valid | out_ready;
  assign in_ready  = (state == IDLE) & out_free & !flush;
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (alu_op == OP_MUL);
  assign load_alu  = accept & (alu_op != OP_MUL);
  assign load_mul  = (state == DONE) & out_free & !flush;

  assign sum   = a + b;
  assign diff  = a - b;
  assign v_add = (a[M] == b[M]) & (sum[M] != a[M]);
  assign v_sub = (a[M] != b[M]) & (diff[M] != a[M]);
  assign lt    = diff[M] ^ v_sub;
  assign shamt = b[SHW-1:0];

  always_comb begin
    bool_y = '0;
    for (int i = 0; i < WIDTH; i++) bool_y[i] = alu_op[{a[i], b[i]}];
  end

  always_comb begin
    r_y   = '0;
    r_v   = 1'b0;
    r_ill = 1'b0;
    case (alu_op)
      OP_ADD:   begin r_y = sum;  r_v = v_add; end
      OP_SUB:   begin r_y = diff; r_v = v_sub; end
      OP_CMPEQ: begin r_y = WIDTH'(diff == '0);        r_v = v_sub; end
      OP_CMPLT: begin r_y = WIDTH'(lt);                r_v = v_sub; end
      OP_CMPLE: begin r_y = WIDTH'(lt | (diff == '0)); r_v = v_sub; end
      OP_SHL:   r_y = a << shamt;
      OP_SHR:   r_y = a >> shamt;
      OP_SRA:   r_y = $unsigned($signed(a) >>> shamt);
      default: begin
        r_ill = !is_legal(alu_op);
        r_y   = r_ill ? '0 : bool_y;
      end
    endcase
    // Compares report the flags of a-b, not of their 0/1 result.
    if (alu_op == OP_CMPEQ || alu_op == OP_CMPLT || alu_op == OP_CMPLE) begin
      r_z = (diff == '0);
      r_n = diff[M];
    end else begin
      r_z = (r_y == '0);
      r_n = r_y[M];
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .last    (mul_last),
    .product (product)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (mul_start) state_nx = BUSY;
      BUSY:    if (mul_last)  state_nx = DONE;
      DONE:    if (out_free)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      z         <= 1'b0;
      v         <= 1'b0;
      n         <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      y         <= r_y;
      z         <= r_z;
      v         <= r_v;
      n         <= r_n;
      illegal   <= r_ill;
    end else if (load_mul) begin
      out_valid <= 1'b1;
      y         <= product;
      z         <= (product == '0);
      v         <= 1'b0;
      n         <= product[M];
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed corner cases, then randomized ops
// with random backpressure checked against an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] y;
    logic        z, v, n, ill;
  } exp_t;

  logic        clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0]  alu_op = 5'd0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, z, v, n, illegal;
  logic [31:0] y;

  logic        in_valid4 = 1'b0;
  logic [4:0]  alu_op4 = 5'd0;
  logic [31:0] a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, z4, v4, n4, ill4;
  logic [31:0] y4;

  exp_t q[$];
  exp_t mon_e, mon_got;
  int   checks = 0, errors = 0;
  bit   rand_bp = 1'b0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .MUL_STEP(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .alu_op(alu_op), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .z(z), .v(v), .n(n), .illegal(illegal));

  alu_pipe #(.WIDTH(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .flush(1'b0), .in_valid(in_valid4),
    .in_ready(in_ready4), .alu_op(alu_op4), .a(a4), .b(b4), .out_valid(out_valid4),
    .out_ready(1'b1), .y(y4), .z(z4), .v(v4), .n(n4), .illegal(ill4));

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] aa, input logic [31:0] bb);
    exp_t        r;
    longint      sa, sb, s;
    logic [31:0] d;
    logic [63:0] p;
    bit          is_cmp;
    r = '0;
    is_cmp = 1'b0;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    d  = aa - bb;
    case (op)
      5'b00000: begin s = sa + sb; r.y = aa + bb; r.v = (s != longint'(int'(s))); end
      5'b00001: begin s = sa - sb; r.y = d;       r.v = (s != longint'(int'(s))); end
      5'b00010: begin p = 64'(aa) * 64'(bb); r.y = p[31:0]; end
      5'b00101, 5'b00111, 5'b01111: begin
        is_cmp = 1'b1;
        s = sa - sb;
        r.v = (s != longint'(int'(s)));
        if (op == 5'b00101)      r.y = {31'd0, aa == bb};
        else if (op == 5'b00111) r.y = {31'd0, sa < sb};
        else                     r.y = {31'd0, sa <= sb};
        r.z = (aa == bb);
        r.n = d[31];
      end
      5'b01000: r.y = aa << (bb % 32);
      5'b01001: r.y = aa >> (bb % 32);
      5'b01011: r.y = 32'($signed(aa) >>> (bb % 32));
      default: begin
        if (op[4]) begin
          for (int i = 0; i < 32; i++) r.y[i] = op[{aa[i], bb[i]}];
        end else begin
          r.ill = 1'b1;
        end
      end
    endcase
    if (!is_cmp) begin
      r.z = (r.y == 0);
      r.n = r.ill ? 1'b0 : r.y[31];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      mon_got = {y, z, v, n, illegal};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got y=%h z=%b v=%b n=%b ill=%b with nothing expected",
                 y, z, v, n, illegal);
      end else begin
        mon_e = q.pop_front();
        if (mon_got !== mon_e) begin
          errors++;
          $display("FAIL result: got y=%h z%b v%b n%b ill%b, expected y=%h z%b v%b n%b ill%b",
                   mon_got.y, mon_got.z, mon_got.v, mon_got.n, mon_got.ill,
                   mon_e.y, mon_e.z, mon_e.v, mon_e.n, mon_e.ill);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Starts and ends at 1 time unit after a rising edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] aa, input logic [31:0] bb);
    alu_op = op; a = aa; b = bb; in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(op, aa, bb));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL issue_timeout: got in_ready=0 for 300 cycles, expected 1");
    in_valid = 1'b0;
  endtask

  task automatic wait_mul(input string name, input bit use4, input int exp_lat);
    int cnt;
    bit stalled_ok;
    cnt = 0;
    stalled_ok = 1'b1;
    while (!(use4 ? out_valid4 : out_valid) && cnt < 100) begin
      if (use4 ? in_ready4 : in_ready) stalled_ok = 1'b0;
      @(posedge clk); #1;
      cnt++;
    end
    check({name, "_latency"}, cnt, exp_lat);
    check({name, "_in_ready_low"}, {31'd0, stalled_ok}, 32'd1);
    check({name, "_y"}, use4 ? y4 : y, 32'hFFFF_FFFF);
  endtask

  logic [4:0]  ops[12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00101, 5'b00111, 5'b01111,
                           5'b01000, 5'b01001, 5'b01011, 5'b11000, 5'b11110, 5'b10110};
  logic [31:0] corners[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h5};

  function automatic logic [31:0] rand_operand();
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    bit          seen;
    logic [4:0]  op;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_y", y, 32'd0);
    check("reset_flags", {28'd0, z, v, n, illegal}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_valid", {31'd0, out_valid}, 32'd1);
    check("add_ovf_y", y, 32'h8000_0000);
    check("add_ovf_zvn", {29'd0, z, v, n}, 32'b011);
    issue(OP_CMPLT, 32'hFFFF_FFFF, 32'h1);
    check("cmplt_y", y, 32'd1);
    issue(OP_CMPLE, 32'd5, 32'd5);
    check("cmple_y", y, 32'd1);
    issue(OP_CMPEQ, 32'd5, 32'd6);
    check("cmpeq_y", y, 32'd0);

    issue(OP_MUL, 32'h0000_FFFF, 32'h0001_0001);
    wait_mul("mul_step1", 1'b0, 33);

    alu_op4 = OP_MUL; a4 = 32'h0000_FFFF; b4 = 32'h0001_0001; in_valid4 = 1'b1;
    @(negedge clk);
    check("mul_step4_accept", {31'd0, in_ready4}, 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    wait_mul("mul_step4", 1'b1, 9);

    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2);
    repeat (4) begin
      check("bp_hold_y", y, 32'd3);
      check("bp_in_ready", {30'd0, out_valid, in_ready}, 32'b10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(OP_SHL, 32'd1, 32'd31);
    check("bp_shl_y", y, 32'h8000_0000);
    @(posedge clk); #1;

    issue(OP_MUL, $urandom, $urandom);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_mul", {y[30:0], out_valid, in_ready}, 33'b1);
    check("rst_mid_mul_y", y, 32'd0);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(OP_MUL, 32'd3, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    alu_op = OP_ADD; a = 32'd7; b = 32'd8; in_valid = 1'b1;
    void'(q.pop_back());
    @(posedge clk); #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_mul_result", {31'd0, seen}, 32'd0);
    issue(5'b00011, $urandom, $urandom);
    check("illegal_out", {y[0], z, illegal, out_valid}, 4'b0111);

    rand_bp = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 4) == 0) op = 5'($urandom);
      else                           op = ops[$urandom_range(0, 11)];
      issue(op, rand_operand(), rand_operand());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain_queue_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
